inst_fetch_unit: RTL and testbench

Instruction fetch stage that sits directly upstream of the decode/execute datapath. It owns the PC and issues instruction reads to instruction memory over an AXI4-Lite-style read channel (AR/R). It presents each fetched instruction with its PC to decode over a valid/ready handshake. It accepts a redirect (jump/branch target) from downstream; sequential PC is PC+4.

---
 rtl/inst_fetch_unit.sv | 153 +++++++++++++++
 tb/tb_inst_fetch_unit.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/inst_fetch_unit.sv
// Instruction fetch stage: owns the PC, issues one AR/R read at a time to
// instruction memory and hands {inst, inst_pc, inst_fault} to decode.
// Redirects from downstream win over everything. An AR that is already on
// the bus is always completed, and its data is thrown away via `drop`.
module inst_fetch_unit #(
    parameter int              XLEN     = 32,
    parameter logic [XLEN-1:0] RESET_PC = 32'h8000_0000
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            fetch_en,
    output logic            mem_arvalid,
    input  logic            mem_arready,
    output logic [XLEN-1:0] mem_araddr,
    input  logic            mem_rvalid,
    output logic            mem_rready,
    input  logic [XLEN-1:0] mem_rdata,
    input  logic [1:0]      mem_rresp,
    output logic            inst_valid,
    input  logic            inst_ready,
    output logic [XLEN-1:0] inst,
    output logic [XLEN-1:0] inst_pc,
    output logic            inst_fault,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc
);

    typedef enum logic [1:0] {IDLE, REQ, RESP, OUT} state_t;

    state_t          state;
    logic [XLEN-1:0] pc;
    logic            drop;
    logic [XLEN-1:0] pc_inc;

    assign pc_inc = pc + XLEN'(4);

    // Single FSM; every output is a register updated on state transitions.
    // Entering REQ loads araddr and raises arvalid only for aligned PCs, so
    // a misaligned PC never reaches the bus.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= IDLE;
            pc          <= RESET_PC;
            drop        <= 1'b0;
            mem_arvalid <= 1'b0;
            mem_araddr  <= '0;
            mem_rready  <= 1'b0;
            inst_valid  <= 1'b0;
            inst        <= '0;
            inst_pc     <= '0;
            inst_fault  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (redirect_valid) begin
                        pc <= redirect_pc;
                        if (fetch_en) begin
                            state       <= REQ;
                            mem_arvalid <= (redirect_pc[1:0] == 2'b00);
                            mem_araddr  <= redirect_pc;
                        end
                    end else if (fetch_en) begin
                        state       <= REQ;
                        mem_arvalid <= (pc[1:0] == 2'b00);
                        mem_araddr  <= pc;
                    end
                end

                REQ: begin
                    if (mem_arvalid) begin
                        // Issued AR stays untouched; a redirect only marks
                        // the coming response as stale.
                        if (redirect_valid) begin
                            pc   <= redirect_pc;
                            drop <= 1'b1;
                        end
                        if (mem_arready) begin
                            mem_arvalid <= 1'b0;
                            mem_rready  <= 1'b1;
                            state       <= RESP;
                        end
                    end else if (redirect_valid) begin
                        // Misaligned PC, nothing on the bus: just retarget.
                        pc <= redirect_pc;
                        if (fetch_en) begin
                            mem_arvalid <= (redirect_pc[1:0] == 2'b00);
                            mem_araddr  <= redirect_pc;
                        end else begin
                            state <= IDLE;
                        end
                    end else begin
                        state      <= OUT;
                        inst_valid <= 1'b1;
                        inst       <= '0;
                        inst_pc    <= pc;
                        inst_fault <= 1'b1;
                    end
                end

                RESP: begin
                    if (redirect_valid) begin
                        pc   <= redirect_pc;
                        drop <= 1'b1;
                    end
                    if (mem_rvalid) begin
                        mem_rready <= 1'b0;
                        if (drop || redirect_valid) begin
                            drop        <= 1'b0;
                            state       <= REQ;
                            mem_arvalid <= redirect_valid ? (redirect_pc[1:0] == 2'b00)
                                                          : (pc[1:0] == 2'b00);
                            mem_araddr  <= redirect_valid ? redirect_pc : pc;
                        end else begin
                            state      <= OUT;
                            inst_valid <= 1'b1;
                            inst       <= mem_rdata;
                            inst_pc    <= pc;
                            inst_fault <= (mem_rresp != 2'b00);
                        end
                    end
                end

                OUT: begin
                    if (redirect_valid) begin
                        // Same-cycle inst_ready is ignored: no pc+4.
                        pc         <= redirect_pc;
                        inst_valid <= 1'b0;
                        if (fetch_en) begin
                            state       <= REQ;
                            mem_arvalid <= (redirect_pc[1:0] == 2'b00);
                            mem_araddr  <= redirect_pc;
                        end else begin
                            state <= IDLE;
                        end
                    end else if (inst_ready) begin
                        pc         <= pc_inc;
                        inst_valid <= 1'b0;
                        if (fetch_en) begin
                            state       <= REQ;
                            mem_arvalid <= (pc_inc[1:0] == 2'b00);
                            mem_araddr  <= pc_inc;
                        end else begin
                            state <= IDLE;
                        end
                    end
                end

                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_inst_fetch_unit.sv
// Directed bench for inst_fetch_unit with a small instruction memory model:
// arready is raised after `ar_delay` waiting cycles, read data comes back the
// cycle after the AR handshake and is addr ^ 32'h8000_0413.
module tb_inst_fetch_unit;

    logic        clk;
    logic        rst;
    logic        fetch_en;
    logic        mem_arvalid;
    logic        mem_arready;
    logic [31:0] mem_araddr;
    logic        mem_rvalid;
    logic        mem_rready;
    logic [31:0] mem_rdata;
    logic [1:0]  mem_rresp;
    logic        inst_valid;
    logic        inst_ready;
    logic [31:0] inst;
    logic [31:0] inst_pc;
    logic        inst_fault;
    logic        redirect_valid;
    logic [31:0] redirect_pc;

    int n_chk = 0;
    int n_err = 0;

    inst_fetch_unit #(.XLEN(32), .RESET_PC(32'h8000_0000)) dut (
        .clk(clk), .rst(rst), .fetch_en(fetch_en),
        .mem_arvalid(mem_arvalid), .mem_arready(mem_arready), .mem_araddr(mem_araddr),
        .mem_rvalid(mem_rvalid), .mem_rready(mem_rready), .mem_rdata(mem_rdata),
        .mem_rresp(mem_rresp),
        .inst_valid(inst_valid), .inst_ready(inst_ready), .inst(inst),
        .inst_pc(inst_pc), .inst_fault(inst_fault),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // memory model
    int          ar_delay = 0;
    logic [1:0]  rresp_cfg = 2'b00;
    int          ar_cnt;
    logic        pend;
    logic [31:0] pend_addr;

    assign mem_arready = mem_arvalid && (ar_cnt >= ar_delay);
    assign mem_rvalid  = pend;
    assign mem_rdata   = pend ? (pend_addr ^ 32'h8000_0413) : 32'h0;
    assign mem_rresp   = pend ? rresp_cfg : 2'b00;

    // memory model state: wait counter and the single pending response
    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            ar_cnt    <= 0;
            pend      <= 1'b0;
            pend_addr <= 32'h0;
        end else begin
            if (mem_arvalid && !mem_arready) ar_cnt <= ar_cnt + 1;
            else                             ar_cnt <= 0;
            if (mem_arvalid && mem_arready) begin
                pend      <= 1'b1;
                pend_addr <= mem_araddr;
            end else if (pend && mem_rready) begin
                pend <= 1'b0;
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b0; fetch_en = 1'b0; inst_ready = 1'b0;
        redirect_valid = 1'b0; redirect_pc = 32'h0;
        tick(); tick();
        chk("rst_arvalid", {31'b0, mem_arvalid}, 32'd0);
        chk("rst_rready",  {31'b0, mem_rready},  32'd0);
        chk("rst_ivalid",  {31'b0, inst_valid},  32'd0);
        chk("rst_inst",    inst,                 32'h0);
        chk("rst_ipc",     inst_pc,              32'h0);
        chk("rst_fault",   {31'b0, inst_fault},  32'd0);

        // basic zero-wait fetch
        rst = 1'b1; fetch_en = 1'b1;
        tick();
        chk("c1_arvalid", {31'b0, mem_arvalid}, 32'd1);
        chk("c1_araddr",  mem_araddr,           32'h8000_0000);
        chk("c1_arready", {31'b0, mem_arready}, 32'd1);
        tick();
        chk("c2_ivalid",  {31'b0, inst_valid},  32'd0);
        chk("c2_rready",  {31'b0, mem_rready},  32'd1);
        tick();
        chk("c3_ivalid",  {31'b0, inst_valid},  32'd1);
        chk("c3_inst",    inst,                 32'h0000_0413);
        chk("c3_ipc",     inst_pc,              32'h8000_0000);
        chk("c3_fault",   {31'b0, inst_fault},  32'd0);

        // decode stalls 5 cycles: output frozen, no new AR
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("stall_out", {inst_valid, mem_arvalid, inst_fault, 29'b0} ^ inst ^ inst_pc,
                {3'b100, 29'b0} ^ 32'h0000_0413 ^ 32'h8000_0000);
            chk("stall_ipc", inst_pc, 32'h8000_0000);
        end
        inst_ready = 1'b1;
        tick();
        inst_ready = 1'b0;
        chk("acc_araddr", mem_araddr,           32'h8000_0004);
        chk("acc_ivalid", {31'b0, inst_valid},  32'd0);
        tick(); tick();
        chk("i2_inst",    inst,                 32'h0000_0417);
        chk("i2_ipc",     inst_pc,              32'h8000_0004);

        // redirect while AR waits for arready
        ar_delay = 3; inst_ready = 1'b1;
        tick();
        inst_ready = 1'b0;
        chk("w0_araddr", mem_araddr, 32'h8000_0008);
        redirect_valid = 1'b1; redirect_pc = 32'h8000_0100;
        tick();
        redirect_valid = 1'b0;
        chk("w1_araddr",  mem_araddr,           32'h8000_0008);
        chk("w1_arvalid", {31'b0, mem_arvalid}, 32'd1);
        tick();
        chk("w2_araddr",  mem_araddr,           32'h8000_0008);
        tick();
        chk("w3_araddr",  mem_araddr,           32'h8000_0008);
        chk("w3_arready", {31'b0, mem_arready}, 32'd1);
        ar_delay = 0;
        tick();
        tick();
        chk("rd_araddr",  mem_araddr,           32'h8000_0100);
        chk("rd_arvalid", {31'b0, mem_arvalid}, 32'd1);
        chk("rd_ivalid",  {31'b0, inst_valid},  32'd0);
        tick(); tick();
        chk("rd_inst",    inst,                 32'h0000_0513);
        chk("rd_ipc",     inst_pc,              32'h8000_0100);

        // misaligned redirect from OUT with same-cycle inst_ready
        redirect_valid = 1'b1; redirect_pc = 32'h8000_0102; inst_ready = 1'b1;
        tick();
        redirect_valid = 1'b0; inst_ready = 1'b0;
        chk("ma_ivalid0", {31'b0, inst_valid},  32'd0);
        chk("ma_arvalid", {31'b0, mem_arvalid}, 32'd0);
        tick();
        chk("ma_ivalid",  {31'b0, inst_valid},  32'd1);
        chk("ma_fault",   {31'b0, inst_fault},  32'd1);
        chk("ma_inst",    inst,                 32'h0);
        chk("ma_ipc",     inst_pc,              32'h8000_0102);
        chk("ma_noar",    {31'b0, mem_arvalid}, 32'd0);

        // error response
        redirect_valid = 1'b1; redirect_pc = 32'h8000_0200;
        tick();
        redirect_valid = 1'b0;
        chk("er_araddr", mem_araddr, 32'h8000_0200);
        rresp_cfg = 2'b10;
        tick(); tick();
        rresp_cfg = 2'b00;
        chk("er_fault",  {31'b0, inst_fault}, 32'd1);
        chk("er_ipc",    inst_pc,             32'h8000_0200);
        inst_ready = 1'b1;
        tick();
        inst_ready = 1'b0;
        chk("er_next",   mem_araddr,          32'h8000_0204);

        // PC wrap
        tick(); tick();
        redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFFC;
        tick();
        redirect_valid = 1'b0;
        chk("wr_araddr", mem_araddr, 32'hFFFF_FFFC);
        tick(); tick();
        chk("wr_ipc",    inst_pc,    32'hFFFF_FFFC);
        chk("wr_inst",   inst,       32'h7FFF_FBEF);
        inst_ready = 1'b1;
        tick();
        inst_ready = 1'b0;
        chk("wr_next",   mem_araddr, 32'h0000_0000);

        // async reset while in RESP
        tick();
        chk("rs_rready", {31'b0, mem_rready}, 32'd1);
        #2 rst = 1'b0;
        #1;
        chk("rs_outs", {mem_arvalid, mem_rready, inst_valid, inst_fault, 28'b0}
                       | inst | inst_pc | mem_araddr, 32'h0);
        tick();
        rst = 1'b1;
        tick();
        chk("rs_araddr", mem_araddr, 32'h8000_0000);

        // redirect in RESP coinciding with rvalid
        tick();
        chk("rr_rvalid", {31'b0, mem_rvalid}, 32'd1);
        redirect_valid = 1'b1; redirect_pc = 32'h8000_0300;
        tick();
        redirect_valid = 1'b0;
        chk("rr_araddr", mem_araddr,          32'h8000_0300);
        chk("rr_ivalid", {31'b0, inst_valid}, 32'd0);
        tick(); tick();
        chk("rr_ipc",    inst_pc,             32'h8000_0300);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
